// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier controller.
// One WIDTH-bit ripple-carry adder, built from full-adder cells, is reused
// across WIDTH iterations. It produces a 2*WIDTH-bit unsigned product and a
// one-cycle done pulse.

// Single-bit full adder cell.
module sm_full_adder (
   input  logic x_i,
   input  logic y_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);
   // Sum and carry of three input bits.
   always_comb begin
      sum_o  = x_i ^ y_i ^ cin_i;
      cout_o = (x_i & y_i) | (cin_i & (x_i ^ y_i));
   end
endmodule

// WIDTH-bit ripple-carry adder made from a chain of full-adder cells.
module sm_ripple_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);
   // carry[k] is the carry into bit k; carry[WIDTH] is the final carry-out.
   logic [WIDTH:0] carry;

   assign carry[0] = cin_i;
   assign cout_o   = carry[WIDTH];

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      sm_full_adder u_fa (
         .x_i    (x_i[k]),
         .y_i    (y_i[k]),
         .cin_i  (carry[k]),
         .sum_o  (sum_o[k]),
         .cout_o (carry[k+1])
      );
   end
endmodule

// Multiplier controller: IDLE -> RUN (WIDTH iterations) -> DONE -> IDLE.
module seq_mult_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   // Iteration counter width; it must hold WIDTH-1, the index of the last step.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;         // multiplicand
   logic [WIDTH-1:0]     acc_q, acc_d;     // A: upper half of the partial product
   logic [WIDTH-1:0]     q_q, q_d;         // Q: multiplier, shifted out LSB first
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   // Shared adder datapath.
   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry_out;
   logic [WIDTH-1:0]     acc_shifted;
   logic [WIDTH-1:0]     q_shifted;

   // The multiplicand is added only when the current multiplier LSB is set.
   assign addend = q_q[0] ? m_q : '0;

   sm_ripple_adder #(.WIDTH(WIDTH)) u_adder (
      .x_i    (acc_q),
      .y_i    (addend),
      .cin_i  (1'b0),
      .sum_o  (sum),
      .cout_o (carry_out)
   );

   // Right shift of {C, S, Q} by one: the carry becomes the new MSB of A,
   // and the LSB of the sum moves into the MSB of Q.
   assign acc_shifted = {carry_out, sum[WIDTH-1:1]};
   assign q_shifted   = {sum[0], q_q[WIDTH-1:1]};

   // Next-state and datapath update logic.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      count_d   = count_q;
      product_d = product_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               count_d = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            acc_d   = acc_shifted;
            q_d     = q_shifted;
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) begin
               product_d = {acc_shifted, q_shifted};
               state_d   = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, with synchronous reset.
   always_ff @(posedge Clock) begin
      // NOTE: every register is reset so that an aborted operation leaves a known zero state; there is no storage array that would need exempting.
      if (Reset) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the values present before the edge.
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Status outputs decoded directly from the registered state.
   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl. A cycle-level behavioural model,
// built on a phase counter and plain multiplication, is compared with the
// DUT on every cycle. Directed scenarios pin the model against
// hand-computed values, and a randomized phase exercises the remaining input space.
module tb_seq_mult_ctrl;
   localparam int W = 4;

   logic              Clock;
   logic              Reset;
   logic              start;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              busy;
   logic              done;
   logic [2*W-1:0]    product;

   int n_vec = 0;
   int n_err = 0;
   bit armed = 0;

   seq_mult_ctrl #(.WIDTH(W)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. phase 0 = idle, 1..W = busy cycles, W+1 = done cycle.
   int             m_phase = 0;
   logic [2*W-1:0] m_prod  = '0;
   logic [2*W-1:0] m_pend  = '0;

   // Model advance on each rising edge, from the same sampled inputs as the DUT.
   always @(posedge Clock) begin
      if (Reset) begin
         m_phase = 0;
         m_prod  = '0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_pend  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            m_phase = 1;
         end
      end else if (m_phase <= W) begin
         if (m_phase == W) begin
            m_prod  = m_pend;
            m_phase = W + 1;
         end else begin
            m_phase = m_phase + 1;
         end
      end else begin
         m_phase = 0;
      end
   end

   // Per-cycle comparison, sampled on the falling edge.
   always @(negedge Clock) begin
      if (armed) begin
         check("busy",    busy,    (m_phase >= 1 && m_phase <= W));
         check("done",    done,    (m_phase == W + 1));
         check("product", product, m_prod);
      end
   end

   // Launch one operation. Return at the falling edge of its done cycle.
   // Optionally pulse start (a=b=1) during RUN, which must be ignored.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit noise, output int lat);
      start = 1'b1;
      a     = av;
      b     = bv;
      lat   = 0;
      do begin
         @(negedge Clock);
         lat++;
         if (lat == 1) start = 1'b0;
         if (noise && lat == 2) begin
            start = 1'b1;
            a     = 4'd1;
            b     = 4'd1;
         end
         if (noise && lat == 3) start = 1'b0;
      end while (!done && lat < 20);
      check("done_seen", done, 1'b1);
   endtask

   int lat;
   int dones;
   int last_done;
   int cyc;

   initial begin
      Reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge Clock);
      armed = 1;
      check("rst_busy",    busy,    1'b0);
      check("rst_done",    done,    1'b0);
      check("rst_product", product, 8'h00);
      Reset = 1'b0;
      @(negedge Clock);

      // Basic multiply.
      run_op(4'd3, 4'd5, 1'b0, lat);
      check("lat_3x5",   lat,     W + 1);
      check("prod_3x5",  product, 8'h0F);
      check("model_3x5", m_prod,  8'h0F);
      @(negedge Clock);

      // Maximum operands, exercising the carry path.
      run_op(4'd15, 4'd15, 1'b0, lat);
      check("lat_15x15",  lat,     W + 1);
      check("prod_15x15", product, 8'hE1);
      @(negedge Clock);

      // Zero operands.
      run_op(4'd0, 4'd9, 1'b0, lat);
      check("lat_0x9",  lat,     W + 1);
      check("prod_0x9", product, 8'h00);
      @(negedge Clock);
      run_op(4'd9, 4'd0, 1'b0, lat);
      check("lat_9x0",  lat,     W + 1);
      check("prod_9x0", product, 8'h00);
      @(negedge Clock);

      // A start asserted during RUN must not launch another operation.
      run_op(4'd7, 4'd6, 1'b1, lat);
      check("lat_7x6",   lat,     W + 1);
      check("prod_7x6",  product, 8'h2A);
      check("model_7x6", m_prod,  8'h2A);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         if (done || busy) dones++;
      end
      check("no_second_op", dones, 0);

      // Reset during RUN, asserted after E2 and sampled at E3.
      start = 1'b1; a = 4'd12; b = 4'd11;
      @(negedge Clock);          // after E0
      start = 1'b0;
      @(negedge Clock);          // after E1
      @(negedge Clock);          // after E2
      Reset = 1'b1;
      @(negedge Clock);
      check("abort_busy",    busy,    1'b0);
      check("abort_done",    done,    1'b0);
      check("abort_product", product, 8'h00);
      Reset = 1'b0;
      repeat (6) begin
         @(negedge Clock);
         check("abort_no_done", done, 1'b0);
      end
      run_op(4'd2, 4'd2, 1'b0, lat);
      check("prod_2x2", product, 8'h04);
      @(negedge Clock);

      // Back-to-back operations with start held high.
      start = 1'b1; a = 4'd15; b = 4'd1;
      dones = 0; last_done = 0; cyc = 0;
      while (dones < 4 && cyc < 60) begin
         @(negedge Clock);
         cyc++;
         if (done) begin
            if (dones == 0) check("b2b_first_lat", cyc, W + 1);
            else            check("b2b_period", cyc - last_done, W + 2);
            check("b2b_product", product, (dones < 2) ? 8'h0F : 8'h1E);
            last_done = cyc;
            dones++;
            if (dones == 2) b = 4'd2;
            if (dones == 4) start = 1'b0;
         end
      end
      check("b2b_count", dones, 4);
      start = 1'b0;
      repeat (3) @(negedge Clock);

      // Randomized stimulus: random start, operands and occasional reset.
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         Reset = ($urandom_range(0, 60) == 0);
         @(negedge Clock);
      end
      Reset = 1'b0;
      start = 1'b0;
      repeat (W + 3) @(negedge Clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
